// File: rtl/hcsr04_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hcsr04_pkg : FSM state type and default timing for the HC-SR04 ranger     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  localparam int DEF_CLK_PER_US = 40;
  localparam int DEF_TRIG_US    = 20;
  localparam int DEF_PERIOD_US  = 60000;
  localparam int DEF_TIMEOUT_US = 25000;
  localparam int DEF_W          = 12;

endpackage
`default_nettype wire

// File: rtl/us_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | us_tick_gen : one-cycle pulse every CLK_PER_US clocks, restartable        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module us_tick_gen #(
  parameter int CLK_PER_US = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] c_last = CW'(CLK_PER_US - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/hcsr04_ranger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hcsr04_ranger : periodic trigger + echo width measurement in microseconds |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int PERIOD_US  = DEF_PERIOD_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int W          = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         echo,
  output logic         trig,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic         timeout,
  output logic         busy
);

  localparam logic [15:0]  c_trig_last    = 16'(TRIG_US - 1);
  localparam logic [15:0]  c_period_last  = 16'(PERIOD_US - 1);
  localparam logic [15:0]  c_timeout_last = 16'(TIMEOUT_US - 1);
  localparam logic [W-1:0] c_sat          = '1;

  state_t       r_state;
  logic         r_sync1, r_echo_s, r_echo_d;
  logic [15:0]  r_period_cnt;
  logic [15:0]  r_to_cnt;
  logic [W-1:0] r_width;
  logic         r_to_flag;

  logic w_tick, w_rise, w_fall, w_start, w_period_end, w_to_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      r_sync1  <= echo;
      r_echo_s <= r_sync1;
      r_echo_d <= r_echo_s;
    end
  end

  assign w_rise       = r_echo_s & ~r_echo_d;
  assign w_fall       = ~r_echo_s & r_echo_d;
  assign w_period_end = w_tick && (r_period_cnt == c_period_last);
  assign w_to_expire  = w_tick && (r_to_cnt == c_timeout_last);
  assign w_start      = enable && ((r_state == IDLE) || (r_state == HOLDOFF && w_period_end));

  // Restart the microsecond divider with each trigger so all us counts are trigger-aligned.
  us_tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(w_start),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      trig         <= 1'b0;
      sample       <= c_sat;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      r_period_cnt <= '0;
      r_to_cnt     <= '0;
      r_width      <= '0;
      r_to_flag    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (w_tick) begin
        r_period_cnt <= r_period_cnt + 16'd1;
        r_to_cnt     <= r_to_cnt + 16'd1;
      end
      case (r_state)
        IDLE: begin
          r_period_cnt <= '0;
          if (enable) begin
            r_state <= TRIG;
            trig    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        TRIG: begin
          if (w_tick && r_period_cnt == c_trig_last) begin
            r_state   <= WAIT_RISE;
            trig      <= 1'b0;
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (w_to_expire) begin
            r_state   <= DONE;
            r_to_flag <= 1'b1;
          end else if (w_rise) begin
            r_state  <= MEASURE;
            r_width  <= '0;
            r_to_cnt <= '0;
          end
        end
        MEASURE: begin
          // The delayed copy is high for exactly the echo length inside MEASURE.
          if (w_tick && r_echo_d && r_width != c_sat) begin
            r_width <= r_width + 1'b1;
          end
          if (w_to_expire) begin
            r_state   <= DONE;
            r_to_flag <= 1'b1;
          end else if (w_fall) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          sample       <= r_to_flag ? c_sat : r_width;
          timeout      <= r_to_flag;
          sample_valid <= 1'b1;
          r_state      <= HOLDOFF;
        end
        HOLDOFF: begin
          if (w_period_end) begin
            if (enable) begin
              r_state      <= TRIG;
              trig         <= 1'b1;
              r_period_cnt <= '0;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
